spi_req_arbiter: RTL and testbench

SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

---
 rtl/spi_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_spi_req_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Shares one SPI slave request port among NUM requesters. A round-robin
//   pointer picks the next requester while idle; that requester's command and
//   lengths are latched and presented to the slave. The winner's write/read
//   handshakes are routed to the slave until the slave reports s_finish. All
//   state advances only on cycles where clk_en is high.
//
//   Optional feature (macro SPI_ARB_TIMEOUT_EN): a watchdog that aborts a
//   transaction after TIMEOUT clk_en cycles in WAIT and pulses m_err.
//   Without the macro m_err is tied low and WAIT waits indefinitely.
//
// Ports
//   clock, rst_n, clk_en          clock, async active-low reset, clock enable
//   m_request/m_cmd/m_len/m_wr_len requester transaction descriptors
//   m_busy/m_finish/m_err          per-requester status (owner only)
//   m_wr_* / m_rd_*                per-requester data handshakes
//   s_*                            slave request, write and read ports
//   grant                          registered one-hot owner, zero when idle
module spi_req_arbiter #(
  parameter int DSIZE   = 8,
  parameter int CSIZE   = 3,
  parameter int NUM     = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic [NUM-1:0]         m_request,
  input  logic [NUM*CSIZE-1:0]   m_cmd,
  input  logic [NUM*24-1:0]      m_len,
  input  logic [NUM*24-1:0]      m_wr_len,
  output logic [NUM-1:0]         m_busy,
  output logic [NUM-1:0]         m_finish,
  input  logic [NUM-1:0]         m_wr_vld,
  input  logic [NUM*DSIZE-1:0]   m_wr_data,
  output logic [NUM-1:0]         m_wr_ready,
  output logic [NUM-1:0]         m_wr_last,
  input  logic [NUM-1:0]         m_rd_ready,
  output logic [NUM-1:0]         m_rd_vld,
  output logic [NUM-1:0]         m_rd_last,
  output logic [DSIZE-1:0]       m_rd_data,
  output logic [NUM-1:0]         m_err,
  output logic                   s_request,
  output logic [CSIZE-1:0]       s_cmd,
  output logic [23:0]            s_len,
  output logic [23:0]            s_wr_len,
  input  logic                   s_busy,
  input  logic                   s_finish,
  output logic                   s_wr_vld,
  output logic [DSIZE-1:0]       s_wr_data,
  input  logic                   s_wr_ready,
  input  logic                   s_wr_last,
  output logic                   s_rd_ready,
  input  logic                   s_rd_vld,
  input  logic                   s_rd_last,
  input  logic [DSIZE-1:0]       s_rd_data,
  output logic [NUM-1:0]         grant
);

  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] next_ptr;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] cand_idx;
  logic          win_found;
  logic [NUM-1:0] win_onehot;
  logic          in_wait;
  int            cand;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);
  logic [31:0]    wdog;
  logic [NUM-1:0] err_q;
  logic           unused_inputs;
  // s_busy carries no information the FSM needs; s_finish ends a transaction.
  assign unused_inputs = s_busy;
  assign m_err = err_q;
`else
  logic unused_inputs;
  assign unused_inputs = ^{s_busy, 32'(TIMEOUT)};
  assign m_err = '0;
`endif

  // Round-robin search: the first requesting index at or after ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM) cand -= NUM;
      cand_idx = PW'(cand);
      if (!win_found && m_request[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_onehot = NUM'(1) << win_idx;

  // Pointer moves past the owner once its transaction ends (normally or aborted).
  always_comb begin
    next_ptr = gidx + 1'b1;
    if (gidx == PW'(NUM - 1)) next_ptr = '0;
  end

  // Main FSM. Nothing changes unless clk_en is high; a low clk_en freezes
  // state, pointer, grant and watchdog so every output simply holds.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      s_cmd    <= '0;
      s_len    <= '0;
      s_wr_len <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      wdog     <= '0;
      err_q    <= '0;
`endif
    end else if (clk_en) begin
`ifdef SPI_ARB_TIMEOUT_EN
      err_q <= '0;
`endif
      case (state)
        IDLE: begin
          if (win_found) begin
            grant    <= win_onehot;
            gidx     <= win_idx;
            s_cmd    <= m_cmd[int'(win_idx)*CSIZE +: CSIZE];
            s_len    <= m_len[int'(win_idx)*24 +: 24];
            s_wr_len <= m_wr_len[int'(win_idx)*24 +: 24];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          wdog <= '0;
`endif
          // A slave may finish immediately; skip WAIT in that case.
          state <= s_finish ? DONE : WAIT;
        end
        WAIT: begin
          if (s_finish) begin
            state <= DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          // The TIMEOUT-th WAIT cycle without s_finish aborts the transfer.
          else if (wdog == WD_LAST) begin
            err_q <= grant;
            grant <= '0;
            ptr   <= next_ptr;
            state <= IDLE;
          end else begin
            wdog <= wdog + 32'd1;
          end
`endif
        end
        DONE: begin
          grant <= '0;
          ptr   <= next_ptr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake routing: only the owner sees slave responses, and the slave
  // only sees valid/ready while the transaction is in WAIT.
  assign in_wait    = (state == WAIT);
  assign s_request  = (state == ISSUE);
  assign s_wr_vld   = in_wait & m_wr_vld[gidx];
  assign s_wr_data  = m_wr_data[int'(gidx)*DSIZE +: DSIZE];
  assign s_rd_ready = in_wait & m_rd_ready[gidx];
  assign m_wr_ready = (in_wait & s_wr_ready) ? grant : '0;
  assign m_wr_last  = (in_wait & s_wr_last)  ? grant : '0;
  assign m_rd_vld   = (in_wait & s_rd_vld)   ? grant : '0;
  assign m_rd_last  = (in_wait & s_rd_last)  ? grant : '0;
  assign m_rd_data  = s_rd_data;
  assign m_busy     = (state != IDLE) ? grant : '0;
  assign m_finish   = (state == DONE) ? grant : '0;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter
//   Self-checking bench for spi_req_arbiter with NUM=2, DSIZE=8, CSIZE=3 and
//   TIMEOUT=10. The timeout scenario is compiled in when SPI_ARB_TIMEOUT_EN
//   is defined; otherwise the bench checks that m_err never fires.
module tb_spi_req_arbiter;

  localparam int DSIZE   = 8;
  localparam int CSIZE   = 3;
  localparam int NUM     = 2;
  localparam int TIMEOUT = 10;

  logic                 clock = 1'b0;
  logic                 rst_n;
  logic                 clk_en;
  logic [NUM-1:0]       m_request;
  logic [NUM*CSIZE-1:0] m_cmd;
  logic [NUM*24-1:0]    m_len;
  logic [NUM*24-1:0]    m_wr_len;
  logic [NUM-1:0]       m_busy;
  logic [NUM-1:0]       m_finish;
  logic [NUM-1:0]       m_wr_vld;
  logic [NUM*DSIZE-1:0] m_wr_data;
  logic [NUM-1:0]       m_wr_ready;
  logic [NUM-1:0]       m_wr_last;
  logic [NUM-1:0]       m_rd_ready;
  logic [NUM-1:0]       m_rd_vld;
  logic [NUM-1:0]       m_rd_last;
  logic [DSIZE-1:0]     m_rd_data;
  logic [NUM-1:0]       m_err;
  logic                 s_request;
  logic [CSIZE-1:0]     s_cmd;
  logic [23:0]          s_len;
  logic [23:0]          s_wr_len;
  logic                 s_busy;
  logic                 s_finish;
  logic                 s_wr_vld;
  logic [DSIZE-1:0]     s_wr_data;
  logic                 s_wr_ready;
  logic                 s_wr_last;
  logic                 s_rd_ready;
  logic                 s_rd_vld;
  logic                 s_rd_last;
  logic [DSIZE-1:0]     s_rd_data;
  logic [NUM-1:0]       grant;

  spi_req_arbiter #(
    .DSIZE(DSIZE), .CSIZE(CSIZE), .NUM(NUM), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en),
    .m_request(m_request), .m_cmd(m_cmd), .m_len(m_len), .m_wr_len(m_wr_len),
    .m_busy(m_busy), .m_finish(m_finish),
    .m_wr_vld(m_wr_vld), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready),
    .m_wr_last(m_wr_last),
    .m_rd_ready(m_rd_ready), .m_rd_vld(m_rd_vld), .m_rd_last(m_rd_last),
    .m_rd_data(m_rd_data), .m_err(m_err),
    .s_request(s_request), .s_cmd(s_cmd), .s_len(s_len), .s_wr_len(s_wr_len),
    .s_busy(s_busy), .s_finish(s_finish),
    .s_wr_vld(s_wr_vld), .s_wr_data(s_wr_data), .s_wr_ready(s_wr_ready),
    .s_wr_last(s_wr_last),
    .s_rd_ready(s_rd_ready), .s_rd_vld(s_rd_vld), .s_rd_last(s_rd_last),
    .s_rd_data(s_rd_data), .grant(grant)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  req;
    logic [2:0]  cmd0;
    logic [2:0]  cmd1;
    logic [23:0] len0;
    logic [23:0] len1;
    logic [23:0] wl0;
    logic [23:0] wl1;
    int          exp_idx;
  } vec_t;

  typedef struct {
    logic [1:0]  grant;
    logic [2:0]  cmd;
    logic [23:0] len;
    logic [23:0] wl;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] wrq[$];
  vec_t       vecs[9];
  vec_t       v;
  logic [7:0] b;
  int         errors = 0;
  int         checks = 0;

  // Single comparison point: every check steps the counters here.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a request pattern and queue what the slave port should show.
  task automatic applyStimulus(input vec_t vi);
    exp_t e;
    m_request = vi.req;
    m_cmd     = {vi.cmd1, vi.cmd0};
    m_len     = {vi.len1, vi.len0};
    m_wr_len  = {vi.wl1, vi.wl0};
    e.grant   = (vi.exp_idx == 1) ? 2'b10 : 2'b01;
    e.cmd     = (vi.exp_idx == 1) ? vi.cmd1 : vi.cmd0;
    e.len     = (vi.exp_idx == 1) ? vi.len1 : vi.len0;
    e.wl      = (vi.exp_idx == 1) ? vi.wl1 : vi.wl0;
    sbq.push_back(e);
  endtask

  // Called one clock after applyStimulus: the slave request must be up.
  task automatic checkGrant();
    exp_t e;
    checkOutput("s_request_latency", 32'(s_request), 32'd1);
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_underflow: got empty queue, expected an entry");
    end else begin
      e = sbq.pop_front();
      checkOutput("grant", 32'(grant), 32'(e.grant));
      checkOutput("s_cmd", 32'(s_cmd), 32'(e.cmd));
      checkOutput("s_len", 32'(s_len), 32'(e.len));
      checkOutput("s_wr_len", 32'(s_wr_len), 32'(e.wl));
      checkOutput("m_busy_issue", 32'(m_busy), 32'(e.grant));
    end
  endtask

  // From WAIT: raise s_finish for one cycle, expect m_finish next cycle.
  task automatic finishTxn(input logic [1:0] g);
    s_finish = 1'b1;
    tick();
    checkOutput("m_finish", 32'(m_finish), 32'(g));
    checkOutput("m_busy_done", 32'(m_busy), 32'(g));
    s_finish = 1'b0;
    tick();
    checkOutput("m_finish_clear", 32'(m_finish), 32'd0);
    checkOutput("grant_idle", 32'(grant), 32'd0);
    checkOutput("m_busy_idle", 32'(m_busy), 32'd0);
  endtask

  task automatic runTxn(input vec_t vi);
    logic [1:0] g;
    g = (vi.exp_idx == 1) ? 2'b10 : 2'b01;
    applyStimulus(vi);
    tick();
    checkGrant();
    tick();
    checkOutput("s_request_wait", 32'(s_request), 32'd0);
    checkOutput("m_busy_wait", 32'(m_busy), 32'(g));
    finishTxn(g);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    // Winners follow from the pointer: starts at 0, moves past each owner.
    vecs[0] = '{2'b01, 3'd5, 3'd2, 24'd100, 24'd200, 24'd4, 24'd8, 0};
    vecs[1] = '{2'b10, 3'd1, 3'd3, 24'd7, 24'd16, 24'd1, 24'd2, 1};
    vecs[2] = '{2'b11, 3'd6, 3'd7, 24'h000001, 24'hFFFFFF, 24'd0, 24'hFFFFFF, 0};
    vecs[3] = '{2'b11, 3'd4, 3'd2, 24'd33, 24'd44, 24'd3, 24'd4, 1};
    vecs[4] = '{2'b11, 3'd0, 3'd7, 24'd55, 24'd66, 24'd5, 24'd6, 0};
    vecs[5] = '{2'b11, 3'd1, 3'd6, 24'd77, 24'd88, 24'd7, 24'd8, 1};
    vecs[6] = '{2'b10, 3'd2, 3'd5, 24'd9, 24'd10, 24'd1, 24'd1, 1};
    vecs[7] = '{2'b01, 3'd7, 3'd0, 24'hABCDEF, 24'd12, 24'h123456, 24'd0, 0};
    vecs[8] = '{2'b11, 3'd3, 3'd4, 24'd13, 24'd14, 24'd2, 24'd3, 1};

    rst_n = 1'b0; clk_en = 1'b1;
    m_request = '0; m_cmd = '0; m_len = '0; m_wr_len = '0;
    m_wr_vld = '0; m_wr_data = '0; m_rd_ready = '0;
    s_busy = 1'b0; s_finish = 1'b0; s_wr_ready = 1'b0; s_wr_last = 1'b0;
    s_rd_vld = 1'b0; s_rd_last = 1'b0; s_rd_data = '0;
    tick();
    tick();
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_s_request", 32'(s_request), 32'd0);
    checkOutput("rst_m_busy", 32'(m_busy), 32'd0);
    checkOutput("rst_m_finish", 32'(m_finish), 32'd0);
    checkOutput("rst_m_err", 32'(m_err), 32'd0);
    checkOutput("rst_s_cmd", 32'(s_cmd), 32'd0);
    checkOutput("rst_s_len", 32'(s_len), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] table-driven arbitration vectors");
    for (int i = 0; i < 9; i++) runTxn(vecs[i]);
    m_request = '0;

    $display("[TB] write/read routing for requester 0");
    v = '{2'b01, 3'd2, 3'd6, 24'd4, 24'd9, 24'd4, 24'd0, 0};
    applyStimulus(v);
    m_wr_vld = 2'b11; m_wr_data = {8'h55, 8'h00}; s_wr_ready = 1'b1;
    tick();
    checkGrant();
    checkOutput("s_wr_vld_issue", 32'(s_wr_vld), 32'd0);
    checkOutput("m_wr_ready_issue", 32'(m_wr_ready), 32'd0);
    m_request = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      b = 8'hA1 + 8'(k);
      m_wr_data[7:0] = b;
      wrq.push_back(b);
      #1;
      checkOutput("s_wr_vld_wait", 32'(s_wr_vld), 32'd1);
      if (s_wr_vld && wrq.size() > 0) checkOutput("s_wr_data", 32'(s_wr_data), 32'(wrq.pop_front()));
      checkOutput("m_wr_ready_owner_only", 32'(m_wr_ready), 32'h1);
      tick();
    end
    s_wr_last = 1'b1;
    #1;
    checkOutput("m_wr_last_owner_only", 32'(m_wr_last), 32'h1);
    m_wr_vld = '0; s_wr_ready = 1'b0; s_wr_last = 1'b0;
    s_rd_vld = 1'b1; s_rd_last = 1'b1; s_rd_data = 8'h3C; m_rd_ready = 2'b11;
    #1;
    checkOutput("s_rd_ready", 32'(s_rd_ready), 32'd1);
    checkOutput("m_rd_vld_owner_only", 32'(m_rd_vld), 32'h1);
    checkOutput("m_rd_last_owner_only", 32'(m_rd_last), 32'h1);
    checkOutput("m_rd_data", 32'(m_rd_data), 32'h3C);
    tick();
    s_rd_vld = 1'b0; s_rd_last = 1'b0; m_rd_ready = '0;
    finishTxn(2'b01);
    checkOutput("s_rd_ready_idle", 32'(s_rd_ready), 32'd0);

    $display("[TB] clk_en low in ISSUE and WAIT");
    v = '{2'b10, 3'd0, 3'd5, 24'd0, 24'd21, 24'd0, 24'd3, 1};
    applyStimulus(v);
    tick();
    checkGrant();
    m_request = '0;
    clk_en = 1'b0; s_finish = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("frozen_s_request", 32'(s_request), 32'd1);
      checkOutput("frozen_m_finish", 32'(m_finish), 32'd0);
    end
    checkOutput("frozen_grant", 32'(grant), 32'h2);
    s_finish = 1'b0; clk_en = 1'b1;
    tick();
    checkOutput("s_request_after_freeze", 32'(s_request), 32'd0);
    clk_en = 1'b0; s_finish = 1'b1;
    tick(); tick(); tick();
    checkOutput("frozen_wait_finish", 32'(m_finish), 32'd0);
    checkOutput("frozen_wait_busy", 32'(m_busy), 32'h2);
    clk_en = 1'b1;
    tick();
    checkOutput("m_finish_after_freeze", 32'(m_finish), 32'h2);
    s_finish = 1'b0;
    tick();
    checkOutput("grant_after_freeze", 32'(grant), 32'd0);

    $display("[TB] request dropped before and after grant");
    clk_en = 1'b0; m_request = 2'b01;
    tick();
    m_request = '0; clk_en = 1'b1;
    tick();
    checkOutput("dropped_before_s_request", 32'(s_request), 32'd0);
    checkOutput("dropped_before_grant", 32'(grant), 32'd0);
    v = '{2'b01, 3'd4, 3'd1, 24'd5, 24'd6, 24'd1, 24'd2, 0};
    applyStimulus(v);
    tick();
    checkGrant();
    m_request = '0;
    tick();
    checkOutput("dropped_after_busy", 32'(m_busy), 32'h1);
    finishTxn(2'b01);

    $display("[TB] s_finish already high in ISSUE");
    v = '{2'b10, 3'd1, 3'd7, 24'd2, 24'd3, 24'd0, 24'd1, 1};
    applyStimulus(v);
    s_finish = 1'b1;
    tick();
    checkGrant();
    m_request = '0;
    tick();
    checkOutput("early_finish_m_finish", 32'(m_finish), 32'h2);
    s_finish = 1'b0;
    tick();
    checkOutput("early_finish_idle", 32'(grant), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    $display("[TB] watchdog abort after TIMEOUT WAIT cycles");
    v = '{2'b01, 3'd6, 3'd1, 24'd8, 24'd9, 24'd2, 24'd3, 0};
    applyStimulus(v);
    tick();
    checkGrant();
    m_request = '0;
    tick();
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      tick();
      checkOutput("m_err_before_limit", 32'(m_err), 32'd0);
    end
    tick();
    checkOutput("m_err_pulse", 32'(m_err), 32'h1);
    checkOutput("abort_grant", 32'(grant), 32'd0);
    checkOutput("abort_m_busy", 32'(m_busy), 32'd0);
    checkOutput("abort_m_finish", 32'(m_finish), 32'd0);
    tick();
    checkOutput("m_err_one_cycle", 32'(m_err), 32'd0);
    v = '{2'b11, 3'd2, 3'd3, 24'd4, 24'd5, 24'd6, 24'd7, 1};
    runTxn(v);
    m_request = '0;
`else
    $display("[TB] no watchdog: WAIT holds indefinitely");
    v = '{2'b01, 3'd6, 3'd1, 24'd8, 24'd9, 24'd2, 24'd3, 0};
    applyStimulus(v);
    tick();
    checkGrant();
    m_request = '0;
    for (int k = 0; k < 3 * TIMEOUT; k++) tick();
    checkOutput("no_watchdog_m_err", 32'(m_err), 32'd0);
    checkOutput("no_watchdog_busy", 32'(m_busy), 32'h1);
    finishTxn(2'b01);
`endif

    $display("[TB] reset asserted in WAIT");
    v = '{2'b01, 3'd5, 3'd2, 24'd30, 24'd31, 24'd3, 24'd4, 0};
    applyStimulus(v);
    tick();
    checkGrant();
    m_request = '0;
    tick();
    s_finish = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_grant", 32'(grant), 32'd0);
    checkOutput("async_rst_m_busy", 32'(m_busy), 32'd0);
    checkOutput("async_rst_m_finish", 32'(m_finish), 32'd0);
    checkOutput("async_rst_m_err", 32'(m_err), 32'd0);
    checkOutput("async_rst_s_cmd", 32'(s_cmd), 32'd0);
    checkOutput("async_rst_s_len", 32'(s_len), 32'd0);
    checkOutput("async_rst_s_wr_len", 32'(s_wr_len), 32'd0);
    tick();
    tick();
    rst_n = 1'b1; s_finish = 1'b0;
    tick();
    checkOutput("post_rst_m_finish", 32'(m_finish), 32'd0);
    checkOutput("post_rst_grant", 32'(grant), 32'd0);

    // Pointer must be back at 0 after reset, so requester 0 wins a tie.
    v = '{2'b11, 3'd3, 3'd4, 24'd40, 24'd41, 24'd5, 24'd6, 0};
    runTxn(v);
    m_request = '0;

    checkOutput("scoreboard_drained", 32'(sbq.size()), 32'd0);
    checkOutput("write_queue_drained", 32'(wrq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
